// File: rtl/wb_queue_pkg.sv
// Shared definitions for the register write-back queue.
//   WBQ_XLEN    default data width of one register write
//   WBQ_AW      register-file address width
//   WBQ_DEPTH   default number of buffered write entries
//   wbq_entry_t one pending register write (destination index + value)
package wb_queue_pkg;
  localparam int WBQ_XLEN  = 32;
  localparam int WBQ_AW    = 5;
  localparam int WBQ_DEPTH = 4;

  typedef struct packed {
    logic [WBQ_AW-1:0]   addr;
    logic [WBQ_XLEN-1:0] data;
  } wbq_entry_t;
endpackage

// File: rtl/wbq_match.sv
// Youngest-match search over the pending write entries for one read port.
//   addr_q/data_q  pending entries in age order, index 0 = oldest (head)
//   vld            per-entry occupancy in the same age order
//   raddr          read-port address to look up
//   hit            some occupied entry targets raddr (never for x0)
//   fwd            data of the youngest matching entry, 0 when no hit
module wbq_match
  import wb_queue_pkg::*;
#(
  parameter int XLEN  = WBQ_XLEN,
  parameter int DEPTH = WBQ_DEPTH
) (
  input  logic [WBQ_AW-1:0] addr_q [DEPTH],
  input  logic [XLEN-1:0]   data_q [DEPTH],
  input  logic [DEPTH-1:0]  vld,
  input  logic [WBQ_AW-1:0] raddr,
  output logic              hit,
  output logic [XLEN-1:0]   fwd
);

  // Scanning oldest to youngest lets a later (younger) match overwrite
  // an earlier one, which yields youngest-wins priority.
  always_comb begin
    hit = 1'b0;
    fwd = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (vld[k] && (addr_q[k] == raddr) && (raddr != '0)) begin
        hit = 1'b1;
        fwd = data_q[k];
      end
    end
  end

endmodule

// File: rtl/wb_queue.sv
// Register write-back queue: buffers accepted register writes and drains
// one per cycle into the register-file write port, with bypass lookup for
// two read ports.
//   clk, rst                 clock, asynchronous active-low reset
//   req_valid/ready          producer handshake for one write
//   req_addr, req_data       destination index / value (x0 writes dropped)
//   flush                    synchronous discard of every pending entry
//   we3, A3, WD3             head entry toward the register-file write port
//   A1, A2 / hit1,2 fwd1,2   read-port bypass lookup
//   count                    number of occupied entries
module wb_queue
  import wb_queue_pkg::*;
#(
  parameter int XLEN  = WBQ_XLEN,
  parameter int DEPTH = WBQ_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [WBQ_AW-1:0]        req_addr,
  input  logic [XLEN-1:0]          req_data,
  input  logic                     flush,
  output logic                     we3,
  output logic [WBQ_AW-1:0]        A3,
  output logic [XLEN-1:0]          WD3,
  input  logic [WBQ_AW-1:0]        A1,
  input  logic [WBQ_AW-1:0]        A2,
  output logic                     hit1,
  output logic                     hit2,
  output logic [XLEN-1:0]          fwd1,
  output logic [XLEN-1:0]          fwd2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WBQ_AW-1:0] addr_mem [DEPTH];
  logic [XLEN-1:0]   data_mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count_q;
  logic              pop;
  logic              push;

  logic [WBQ_AW-1:0] ord_addr [DEPTH];
  logic [XLEN-1:0]   ord_data [DEPTH];
  logic [DEPTH-1:0]  ord_vld;

  // The register file takes one write per cycle, so the head always drains.
  assign pop = (count_q != '0);

  assign req_ready = flush
                  || (count_q < CW'(DEPTH))
                  || ((count_q == CW'(DEPTH)) && pop);

  // x0 requests complete the handshake but never occupy an entry; flush
  // takes precedence over anything offered in the same cycle.
  assign push = req_valid && req_ready && (req_addr != '0) && !flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // Payload storage is never reset; occupancy alone decides visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= req_addr;
      data_mem[wr_ptr] <= req_data;
    end
  end

  assign we3   = pop;
  assign A3    = pop ? addr_mem[rd_ptr] : '0;
  assign WD3   = pop ? data_mem[rd_ptr] : '0;
  assign count = count_q;

  // Present the ring in age order (0 = head) so the match search does not
  // need to know about pointer wrap.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      ord_addr[k] = addr_mem[rd_ptr + PW'(k)];
      ord_data[k] = data_mem[rd_ptr + PW'(k)];
      ord_vld[k]  = (CW'(k) < count_q);
    end
  end

  wbq_match #(.XLEN(XLEN), .DEPTH(DEPTH)) u_match1 (
    .addr_q (ord_addr),
    .data_q (ord_data),
    .vld    (ord_vld),
    .raddr  (A1),
    .hit    (hit1),
    .fwd    (fwd1)
  );

  wbq_match #(.XLEN(XLEN), .DEPTH(DEPTH)) u_match2 (
    .addr_q (ord_addr),
    .data_q (ord_data),
    .vld    (ord_vld),
    .raddr  (A2),
    .hit    (hit2),
    .fwd    (fwd2)
  );

endmodule
